// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: channel opcodes and the arbiter state encoding.
package tlul_pkg;

  // A-channel request opcodes
  localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] OP_GET              = 3'd4;

  // D-channel response opcodes
  localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

  // Arbiter transaction phases: one transaction in flight at a time
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_SEND = 2'd1,
    ST_D_WAIT = 2'd2,
    ST_D_SEND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tlul_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, wrapping around to index 0.
module tlul_rr_pick
  import tlul_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          any,
  output logic [GW-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             pos_s;

  // Rotate the request vector so that bit 0 corresponds to ptr
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N-1:0];
  end

  // Scan the rotated vector from bit 0 and map the first hit back to a master index
  always_comb begin
    any   = 1'b0;
    idx   = {GW{1'b0}};
    pos_s = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot_s[k]) begin
        any   = 1'b1;
        pos_s = (int'(ptr) + k) % N;
        idx   = GW'(pos_s);
      end else begin
        any   = any;
      end
    end
  end

endmodule

// File: rtl/tlul_uart_arbiter.sv
// Shares one TL-UL UART slave port between N masters. Round-robin grant on
// channel A, one transaction in flight, D response routed back by grant index.
module tlul_uart_arbiter
  import tlul_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8,
  parameter int A = 32,
  parameter int Z = 4,
  parameter int O = 5,
  parameter int I = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  // master A channels (master i in slice i)
  input  logic [N*3-1:0]   m_a_opcode,
  input  logic [N*3-1:0]   m_a_param,
  input  logic [N*Z-1:0]   m_a_size,
  input  logic [N*O-1:0]   m_a_source,
  input  logic [N*A-1:0]   m_a_address,
  input  logic [N*W-1:0]   m_a_mask,
  input  logic [N*8*W-1:0] m_a_data,
  input  logic [N-1:0]     m_a_valid,
  output logic [N-1:0]     m_a_ready,
  // master D channels (fields broadcast, valid per master)
  output logic [N*3-1:0]   m_d_opcode,
  output logic [N*2-1:0]   m_d_param,
  output logic [N*Z-1:0]   m_d_size,
  output logic [N*O-1:0]   m_d_source,
  output logic [N*I-1:0]   m_d_sink,
  output logic [N*8*W-1:0] m_d_data,
  output logic [N-1:0]     m_d_error,
  output logic [N-1:0]     m_d_valid,
  input  logic [N-1:0]     m_d_ready,
  // slave A channel
  output logic [2:0]       s_a_opcode,
  output logic [2:0]       s_a_param,
  output logic [Z-1:0]     s_a_size,
  output logic [O-1:0]     s_a_source,
  output logic [A-1:0]     s_a_address,
  output logic [W-1:0]     s_a_mask,
  output logic [8*W-1:0]   s_a_data,
  output logic             s_a_valid,
  input  logic             s_a_ready,
  // slave D channel
  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_param,
  input  logic [Z-1:0]     s_d_size,
  input  logic [O-1:0]     s_d_source,
  input  logic [I-1:0]     s_d_sink,
  input  logic [8*W-1:0]   s_d_data,
  input  logic             s_d_error,
  input  logic             s_d_valid,
  output logic             s_d_ready
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = 8 * W;

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [2:0]      s_a_opcode_q, s_a_opcode_d;
  logic [2:0]      s_a_param_q, s_a_param_d;
  logic [Z-1:0]    s_a_size_q, s_a_size_d;
  logic [O-1:0]    s_a_source_q, s_a_source_d;
  logic [A-1:0]    s_a_address_q, s_a_address_d;
  logic [W-1:0]    s_a_mask_q, s_a_mask_d;
  logic [DW-1:0]   s_a_data_q, s_a_data_d;
  logic            s_a_valid_q, s_a_valid_d;
  logic            s_d_ready_q, s_d_ready_d;

  logic [2:0]      d_opcode_q, d_opcode_d;
  logic [1:0]      d_param_q, d_param_d;
  logic [Z-1:0]    d_size_q, d_size_d;
  logic [O-1:0]    d_source_q, d_source_d;
  logic [I-1:0]    d_sink_q, d_sink_d;
  logic [DW-1:0]   d_data_q, d_data_d;
  logic            d_error_q, d_error_d;
  logic [N-1:0]    m_d_valid_q, m_d_valid_d;

  logic [N-1:0]    m_a_ready_s;
  logic            pick_any_s;
  logic [GW-1:0]   pick_idx_s;

  tlul_rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req (m_a_valid),
    .ptr (rr_ptr_q),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Next-state, capture and grant logic for the four transaction phases
  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    rr_ptr_d      = rr_ptr_q;
    s_a_opcode_d  = s_a_opcode_q;
    s_a_param_d   = s_a_param_q;
    s_a_size_d    = s_a_size_q;
    s_a_source_d  = s_a_source_q;
    s_a_address_d = s_a_address_q;
    s_a_mask_d    = s_a_mask_q;
    s_a_data_d    = s_a_data_q;
    s_a_valid_d   = s_a_valid_q;
    s_d_ready_d   = s_d_ready_q;
    d_opcode_d    = d_opcode_q;
    d_param_d     = d_param_q;
    d_size_d      = d_size_q;
    d_source_d    = d_source_q;
    d_sink_d      = d_sink_q;
    d_data_d      = d_data_q;
    d_error_d     = d_error_q;
    m_d_valid_d   = m_d_valid_q;
    m_a_ready_s   = {N{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          m_a_ready_s[pick_idx_s] = 1'b1;
          g_d           = pick_idx_s;
          s_a_opcode_d  = m_a_opcode[pick_idx_s*3 +: 3];
          s_a_param_d   = m_a_param[pick_idx_s*3 +: 3];
          s_a_size_d    = m_a_size[pick_idx_s*Z +: Z];
          s_a_source_d  = m_a_source[pick_idx_s*O +: O];
          s_a_address_d = m_a_address[pick_idx_s*A +: A];
          s_a_mask_d    = m_a_mask[pick_idx_s*W +: W];
          s_a_data_d    = m_a_data[pick_idx_s*DW +: DW];
          s_a_valid_d   = 1'b1;
          state_d       = ST_A_SEND;
        end else begin
          state_d       = ST_IDLE;
        end
      end
      ST_A_SEND: begin
        if (s_a_valid_q && s_a_ready) begin
          s_a_valid_d = 1'b0;
          s_d_ready_d = 1'b1;
          state_d     = ST_D_WAIT;
        end else begin
          state_d     = ST_A_SEND;
        end
      end
      ST_D_WAIT: begin
        if (s_d_valid && s_d_ready_q) begin
          d_opcode_d  = s_d_opcode;
          d_param_d   = s_d_param;
          d_size_d    = s_d_size;
          d_source_d  = s_d_source;
          d_sink_d    = s_d_sink;
          d_data_d    = s_d_data;
          d_error_d   = s_d_error;
          s_d_ready_d = 1'b0;
          m_d_valid_d = {N{1'b0}};
          m_d_valid_d[g_q] = 1'b1;
          state_d     = ST_D_SEND;
        end else begin
          state_d     = ST_D_WAIT;
        end
      end
      ST_D_SEND: begin
        if (m_d_ready[g_q]) begin
          m_d_valid_d = {N{1'b0}};
          if (g_q == GW'(N - 1)) begin
            rr_ptr_d  = {GW{1'b0}};
          end else begin
            rr_ptr_d  = g_q + GW'(1);
          end
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_D_SEND;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        s_a_valid_d = 1'b0;
        s_d_ready_d = 1'b0;
        m_d_valid_d = {N{1'b0}};
      end
    endcase
  end

  // State, grant and captured channel registers; reset abandons any transaction
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      g_q           <= {GW{1'b0}};
      rr_ptr_q      <= {GW{1'b0}};
      s_a_opcode_q  <= 3'd0;
      s_a_param_q   <= 3'd0;
      s_a_size_q    <= {Z{1'b0}};
      s_a_source_q  <= {O{1'b0}};
      s_a_address_q <= {A{1'b0}};
      s_a_mask_q    <= {W{1'b0}};
      s_a_data_q    <= {DW{1'b0}};
      s_a_valid_q   <= 1'b0;
      s_d_ready_q   <= 1'b0;
      d_opcode_q    <= 3'd0;
      d_param_q     <= 2'd0;
      d_size_q      <= {Z{1'b0}};
      d_source_q    <= {O{1'b0}};
      d_sink_q      <= {I{1'b0}};
      d_data_q      <= {DW{1'b0}};
      d_error_q     <= 1'b0;
      m_d_valid_q   <= {N{1'b0}};
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      rr_ptr_q      <= rr_ptr_d;
      s_a_opcode_q  <= s_a_opcode_d;
      s_a_param_q   <= s_a_param_d;
      s_a_size_q    <= s_a_size_d;
      s_a_source_q  <= s_a_source_d;
      s_a_address_q <= s_a_address_d;
      s_a_mask_q    <= s_a_mask_d;
      s_a_data_q    <= s_a_data_d;
      s_a_valid_q   <= s_a_valid_d;
      s_d_ready_q   <= s_d_ready_d;
      d_opcode_q    <= d_opcode_d;
      d_param_q     <= d_param_d;
      d_size_q      <= d_size_d;
      d_source_q    <= d_source_d;
      d_sink_q      <= d_sink_d;
      d_data_q      <= d_data_d;
      d_error_q     <= d_error_d;
      m_d_valid_q   <= m_d_valid_d;
    end
  end

  // Grant ready is combinational for the winner; forced low while reset is held
  always_comb begin
    m_a_ready = m_a_ready_s & {N{RST_N}};
  end

  assign s_a_opcode  = s_a_opcode_q;
  assign s_a_param   = s_a_param_q;
  assign s_a_size    = s_a_size_q;
  assign s_a_source  = s_a_source_q;
  assign s_a_address = s_a_address_q;
  assign s_a_mask    = s_a_mask_q;
  assign s_a_data    = s_a_data_q;
  assign s_a_valid   = s_a_valid_q;
  assign s_d_ready   = s_d_ready_q;

  assign m_d_opcode  = {N{d_opcode_q}};
  assign m_d_param   = {N{d_param_q}};
  assign m_d_size    = {N{d_size_q}};
  assign m_d_source  = {N{d_source_q}};
  assign m_d_sink    = {N{d_sink_q}};
  assign m_d_data    = {N{d_data_q}};
  assign m_d_error   = {N{d_error_q}};
  assign m_d_valid   = m_d_valid_q;

endmodule

// File: doc/tlul_uart_arbiter.md
# tlul_uart_arbiter

Shares the single TL-UL UART slave port between N TL-UL masters, such as the echo master and a future configuration master. Round-robin arbitration on channel A; exactly one transaction in flight at a time. The D-channel response is routed back to the master that issued the request. Sits between the masters and the UART slave in the top-level TL-UL fabric.

## Interface
Parameters:
- N, 2, number of masters (1..8)
- W, 8, data bus width in bytes
- A, 32, address width
- Z, 4, size field width
- O, 5, source width
- I, 5, sink width

Ports. Master-side buses are flattened; master i occupies slice [i*X +: X].
- CLK  in  1  clock, all state changes on rising edge
- RST_N  in  1  asynchronous active-low reset
- m_a_opcode/m_a_param/m_a_size/m_a_source/m_a_address/m_a_mask/m_a_data  in  N×(3/3/Z/O/A/W/8W)  master A fields
- m_a_valid  in  N  master A valid
- m_a_ready  out  N  master A ready
- m_d_opcode/m_d_param/m_d_size/m_d_source/m_d_sink/m_d_data/m_d_error  out  N×(3/2/Z/O/I/8W/1)  D fields, broadcast to all masters
- m_d_valid  out  N  per-master D valid
- m_d_ready  in  N  per-master D ready
- s_a_opcode … s_a_data  out  3/3/Z/O/A/W/8W  slave A fields (registered)
- s_a_valid  out  1 ; s_a_ready  in  1
- s_d_opcode … s_d_error  in  3/2/Z/O/I/8W/1 ; s_d_valid  in  1 ; s_d_ready  out  1

## Operation
- State machine states: IDLE, A_SEND, D_WAIT, D_SEND. Registers: grant g (clog2 N bits), rr_ptr.
- IDLE: if any m_a_valid, the winner is the first set bit at or after rr_ptr, wrapping. m_a_ready[g] is high combinationally for the winner only. On that edge, capture the winner's A fields into the s_a_* registers and set s_a_valid=1. Next state A_SEND.
- A_SEND: hold s_a_* stable. When s_a_valid&s_a_ready: s_a_valid←0, s_d_ready←1, next state D_WAIT.
- D_WAIT: when s_d_valid&s_d_ready: capture D fields, s_d_ready←0, m_d_valid[g]←1, next state D_SEND.
- D_SEND: hold fields. When m_d_ready[g]: m_d_valid←0, rr_ptr←(g+1) mod N, next state IDLE.
- a_source, d_source, d_sink and d_error pass through unmodified. Routing uses g only, never source.
- m_a_ready is 0 for every master outside IDLE. Non-winning requests wait and are not dropped.

## Timing
- Reset values: s_a_valid=0, s_d_ready=0, m_d_valid=0, m_a_ready=0, all captured field registers 0, state IDLE, rr_ptr=0, g=0.
- Master accept at cycle t; s_a_valid is high from t+1.
- Slave D accept at cycle u; m_d_valid[g] is high from u+1.
- Minimum occupancy is 4 cycles per transaction when the slave is zero-wait. The next grant can occur on the cycle after D_SEND completes.
- Simultaneous requests from all N masters are served in order rr_ptr, rr_ptr+1, …, so each master waits at most N−1 transactions.
- N=1: the arbiter degenerates to a registered pass-through with the same state sequence.
- s_d_valid in IDLE or A_SEND is ignored (s_d_ready=0). The slave must not do this.
- Reset mid-operation: the in-flight transaction is abandoned and no D beat is delivered. All outputs take their reset values immediately (asynchronous).

## Structure
- Shared package tlul_pkg holds the opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1) and the state enum. The block imports these and does not redefine them.
- One sub-module, tlul_rr_pick: combinational round-robin picker. Inputs are req[N] and ptr; outputs are any and idx.

## Test plan
- Single Get from master 0: address=127, size=3, slave returns AccessAckData data=0x1122334455667788 after 2 cycles. Required: s_a_valid one cycle after accept, m_d_valid[0] with that data, m_d_valid[1] stays 0.
- Both masters request in the same cycle after reset. Required: master 0 is granted first, then master 1 (PutFullData, data=0xA5…), with rr_ptr=0 after the second transaction.
- Slave stalls: s_a_ready low for 5 cycles. Required: s_a_* fields stable and s_a_valid held high for 5 cycles, and no m_a_ready asserted meanwhile.
- Master holds m_d_ready[1]=0 for 3 cycles. Required: m_d_valid[1] held and fields stable, and a new request from master 0 is not accepted until completion.
- d_error=1 with source=5 returned. Required: forwarded unchanged to the granted master.
- RST_N pulsed low while in D_WAIT. Required: all outputs reset asynchronously, no D delivered, and the next request is served normally starting from master 0.
